// File: rtl/stream_buffer_mux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_buffer_mux
//  Description : N-way channel select feeding a cyclic sample buffer with a
//                selectable overflow policy, drained through a registered
//                valid/ready output stage. Saturating input/drop statistics
//                are exposed for debug display.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_buffer_mux #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 3,
    parameter int SEL_WIDTH  = 2,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   ch_data,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic                   overwrite_mode,
    input  logic                   drain_en,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_WIDTH-1:0]   active_sel,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_WIDTH:0]    count,
    output logic [ADDR_WIDTH-1:0]  wr_ptr,
    output logic [ADDR_WIDTH-1:0]  rd_ptr,
    output logic [CNT_WIDTH-1:0]   in_count,
    output logic [CNT_WIDTH-1:0]   drop_count
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  c_STAT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  c_STAT_ONE  = CNT_WIDTH'(1);
    localparam logic [31:0]           c_NCH_U     = 32'(NCH);

    // Registered state
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr;
    logic [ADDR_WIDTH:0]    r_count;
    logic [SEL_WIDTH-1:0]   r_active_sel;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_out_valid;
    logic [CNT_WIDTH-1:0]   r_in_count;
    logic [CNT_WIDTH-1:0]   r_drop_count;

    // Combinational decode
    logic [WIDTH-1:0]       w_ch_sample [NCH];
    logic [SEL_WIDTH-1:0]   w_sel_mapped;
    logic                   w_push;
    logic [WIDTH-1:0]       w_push_data;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;
    logic                   w_ovw;
    logic                   w_cnt_inc;
    logic                   w_cnt_dec;

    // Split the packed channel bus into one sample per channel
    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign w_ch_sample[k] = ch_data[k*WIDTH +: WIDTH];
    end

    // Out-of-range select requests fall back to channel 0
    assign w_sel_mapped = (32'(sel) < c_NCH_U) ? sel : '0;

    // Route strobe and sample of the currently active channel only
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_active_sel == SEL_WIDTH'(k)) begin
                w_push      = ch_valid[k];
                w_push_data = w_ch_sample[k];
            end
        end
    end

    // Pop whenever the output register is free or being emptied this cycle;
    // a simultaneous pop always makes room, so a push next to a pop never drops
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_pop     = drain_en && (r_count != '0) && (!r_out_valid || out_ready);
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_ovw     = w_drop && overwrite_mode;
    assign w_wr      = w_push && (!w_full || w_pop || overwrite_mode);
    // Overwrite keeps count at DEPTH, so only a non-full write grows it
    assign w_cnt_inc = w_wr && !w_pop && !w_full;
    assign w_cnt_dec = w_pop && !w_wr;

    // Channel switch only on a cycle with no sample on the old channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_sel <= '0;
        end else if (!w_push) begin
            r_active_sel <= w_sel_mapped;
        end
    end

    // Sample storage; contents are deliberately not cleared on reset
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; overwrite advances rd_ptr past the
    // oldest entry, which is the same slot being written
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop || w_ovw) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_cnt_inc) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_cnt_dec) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Output register: load on pop, clear after an accepted transfer;
    // drain_en only gates loads, it never retracts a held sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_data  <= r_mem[r_rd_ptr];
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating statistics for accepted-channel strobes and lost samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push && (r_in_count != c_STAT_MAX)) begin
                r_in_count <= r_in_count + c_STAT_ONE;
            end
            if (w_drop && (r_drop_count != c_STAT_MAX)) begin
                r_drop_count <= r_drop_count + c_STAT_ONE;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign active_sel = r_active_sel;
    assign empty      = (r_count == '0);
    assign full       = w_full;
    assign count      = r_count;
    assign wr_ptr     = r_wr_ptr;
    assign rd_ptr     = r_rd_ptr;
    assign in_count   = r_in_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: doc/stream_buffer_mux.md
Name: stream_buffer_mux

Overview:
Parametrised source-select plus cyclic buffer plus ready/valid drain stage that sits between the RX-side sources (raw UART byte stream, MA filter, FIR filter, ...) and the UART TX.
It generalises the current fixed 3-way priority mux and single-policy buffer:
- NCH channels, selected by an index.
- Channel switching only at a sample boundary.
- Selectable overflow policy: drop-new or overwrite-oldest.
- A registered output stage with a true valid/ready handshake, so no external edge-detected read pulse is needed.
- Saturating input and drop statistics for HEX debug.

Parameters:
- WIDTH, 8, sample width in bits.
- NCH, 3, number of input channels (>=1).
- SEL_WIDTH, 2, width of sel; must be >= clog2(NCH), minimum 1.
- DEPTH, 512, buffer entries; power of two.
- ADDR_WIDTH, 9, log2(DEPTH).
- CNT_WIDTH, 16, width of the statistic counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ch_data  in  NCH*WIDTH  channel samples; channel k occupies bits [k*WIDTH +: WIDTH].
- ch_valid  in  NCH  one-cycle strobe per channel sample.
- sel  in  SEL_WIDTH  requested channel; values >= NCH map to channel 0.
- overwrite_mode  in  1  0 = drop new sample when full; 1 = discard oldest entry.
- drain_en  in  1  enables loading of the output stage (TX gate).
- out_data  out  WIDTH  output sample, registered.
- out_valid  out  1  out_data holds a sample.
- out_ready  in  1  sink accepts; a transfer occurs when out_valid && out_ready.
- active_sel  out  SEL_WIDTH  channel currently routed.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  ADDR_WIDTH+1  entries held in the memory array; excludes the output register.
- wr_ptr  out  ADDR_WIDTH  write pointer.
- rd_ptr  out  ADDR_WIDTH  read pointer.
- in_count  out  CNT_WIDTH  samples presented on the active channel; saturating.
- drop_count  out  CNT_WIDTH  samples lost, either new or oldest; saturating.

Behaviour:
- **Reset (synchronous, rst=1 at an edge).** The following all go to 0: out_data, out_valid, active_sel, wr_ptr, rd_ptr, count, in_count, drop_count. Buffer contents are discarded. Reset mid-transfer drops any held sample without completing it. Memory contents are not cleared.
- **Channel select.**
  - active_sel <= mapped(sel) only on an edge where ch_valid[active_sel]==0.
  - A sample present while the change is requested is taken from the old channel.
  - ch_valid on non-active channels is ignored and not counted.
- **Push.** A push is requested when ch_valid[active_sel]==1. Each push increments in_count, saturating at all-ones.
- **Pop.** A pop occurs on an edge when drain_en && count!=0 && (!out_valid || out_ready).
  - On a pop: out_data <= mem[rd_ptr], out_valid <= 1, rd_ptr++ (mod DEPTH).
  - If out_valid && out_ready && no pop, then out_valid <= 0.
  - drain_en=0 never retracts a held out_valid; it only blocks new loads.
  - out_data is stable while out_valid && !out_ready.
- **Write rules.**
  - Not full, or pop in the same cycle: write mem[wr_ptr], wr_ptr++.
  - Full, no pop, overwrite_mode=0: sample dropped, pointers unchanged, drop_count++.
  - Full, no pop, overwrite_mode=1: write mem[wr_ptr], wr_ptr++, rd_ptr++; count stays DEPTH; drop_count++.
- **Count.** +1 on a write without a pop, -1 on a pop without a write, unchanged when both or neither occur. It never exceeds DEPTH and never underflows. Pointers wrap DEPTH-1 -> 0.
- **Latency.** A sample strobed in cycle N gives count=1 in N+1. If drain_en and the output stage is free, out_valid=1 in N+2 and count returns to 0. Sustained throughput is one sample per cycle when out_ready is held high.
- **Flags.** empty, full and count are registered-state derived and reflect post-edge state.
- **Ordering.** Output order equals accepted-write order.
- **Counter saturation.** drop_count and in_count hold at 2^CNT_WIDTH-1.

Test Plan:
1. Reset, sel=1, drain_en=1, out_ready=1; push 0x11,0x22,0x33 on channel 1 in consecutive cycles -> out_data 0x11,0x22,0x33 on consecutive cycles, first out_valid 2 cycles after the first strobe; in_count=3, drop_count=0, empty=1 at end.
2. DEPTH=4, drain_en=0, overwrite_mode=0; push 0x01..0x06 -> full=1, count=4, drop_count=2. Then drain_en=1, out_ready=1 -> outputs 0x01,0x02,0x03,0x04.
3. DEPTH=4, drain_en=0, overwrite_mode=1; push 0x01..0x06 -> count=4, drop_count=2, wr_ptr=rd_ptr=2. Drain -> outputs 0x03,0x04,0x05,0x06.
4. Full DEPTH=4 buffer, drain_en=1, out_valid=1, out_ready=1, push 0x77 in the same cycle as a pop -> no drop, count stays 4, 0x77 emerges last.
5. Strobe ch_valid[0] every cycle while sel changes 0->2 -> active_sel stays 0 until the first cycle with ch_valid[0]=0, then becomes 2. Channel-2 strobes before the switch are not counted. Also check that sel=3 with NCH=3 maps to 0.
6. out_valid=1, out_ready=0 held 10 cycles with pushes -> out_data stable, no loss. Assert rst mid-stream -> next cycle out_valid=0, count=0, in_count=0, drop_count=0.
